// File: rtl/nzcv_cond_unit.sv
// nzcv_cond_unit: architectural NZCV flag register plus conditional-branch
// resolver. Queries are evaluated against the forwarded or stored flags.
// The taken/next-PC result is held in a one-entry valid/ready output register.
module nzcv_cond_unit #(
   parameter int         N          = 64,
   parameter int         CNT_W      = 16,
   parameter logic [3:0] RESET_NZCV = 4'b0000
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [3:0]       i_nzcv,
   input  logic             i_set_flags,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [3:0]       i_cond,
   input  logic [N-1:0]     i_pc,
   input  logic [N-1:0]     i_target,
   output logic             o_valid,
   input  logic             i_ready,
   output logic             o_taken,
   output logic [N-1:0]     o_next_pc,
   output logic [3:0]       o_flags,
   output logic [CNT_W-1:0] o_taken_cnt
);

   logic [3:0]       r_flags;
   logic             r_valid;
   logic             r_taken;
   logic [N-1:0]     r_next_pc;
   logic [CNT_W-1:0] r_taken_cnt;

   logic [3:0]       w_flags;
   logic             w_n, w_z, w_c, w_v;
   logic             w_base;
   logic             w_taken;
   logic             w_accept;
   logic [N-1:0]     w_next_pc;

   // A same-cycle flag write is forwarded so the query sees the newest flags.
   assign w_flags  = i_set_flags ? i_nzcv : r_flags;
   assign w_n      = w_flags[3];
   assign w_z      = w_flags[2];
   assign w_c      = w_flags[1];
   assign w_v      = w_flags[0];

   // The output register can take a new result when empty or draining this cycle.
   assign o_ready  = ~r_valid | i_ready;
   assign w_accept = i_valid & o_ready;

   // Base condition from cond[3:1]; low bit inverts it.
   always_comb begin
      w_base = 1'b1;
      case (i_cond[3:1])
         3'b000:  w_base = w_z;
         3'b001:  w_base = w_c;
         3'b010:  w_base = w_n;
         3'b011:  w_base = w_v;
         3'b100:  w_base = w_c & ~w_z;
         3'b101:  w_base = (w_n == w_v);
         3'b110:  w_base = ~w_z & (w_n == w_v);
         default: w_base = 1'b1;
      endcase
   end

   // NV (1111) is architecturally "always", so it must not invert AL.
   assign w_taken   = (i_cond == 4'b1111) ? 1'b1 : (w_base ^ i_cond[0]);
   assign w_next_pc = w_taken ? i_target : (i_pc + N'(4));

   // Flag register: written whenever requested, regardless of the query handshake.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_flags <= RESET_NZCV;
      end else if (i_set_flags) begin
         r_flags <= i_nzcv;
      end
   end

   // Output stage: load on accept, drop valid once consumed, hold while stalled.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_valid   <= 1'b0;
         r_taken   <= 1'b0;
         r_next_pc <= '0;
      end else if (w_accept) begin
         r_valid   <= 1'b1;
         r_taken   <= w_taken;
         r_next_pc <= w_next_pc;
      end else if (r_valid && i_ready) begin
         r_valid   <= 1'b0;
      end
   end

   // Saturating count of taken branches, counted at accept time.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_taken_cnt <= '0;
      end else if (w_accept && w_taken && (r_taken_cnt != {CNT_W{1'b1}})) begin
         r_taken_cnt <= r_taken_cnt + CNT_W'(1);
      end
   end

   assign o_valid     = r_valid;
   assign o_taken     = r_taken;
   assign o_next_pc   = r_next_pc;
   assign o_flags     = r_flags;
   assign o_taken_cnt = r_taken_cnt;

endmodule

// File: tb/tb_nzcv_cond_unit.sv
// Testbench for nzcv_cond_unit: directed scenarios plus random traffic,
// checked against a behavioural model of the flag/condition/output rules.
module tb_nzcv_cond_unit;
   localparam int N = 64;

   logic          i_clk = 1'b0;
   logic          i_rst_n = 1'b0;
   logic [3:0]    i_nzcv = 4'h0;
   logic          i_set_flags = 1'b0;
   logic          i_valid = 1'b0;
   logic          o_ready;
   logic [3:0]    i_cond = 4'h0;
   logic [N-1:0]  i_pc = '0;
   logic [N-1:0]  i_target = '0;
   logic          o_valid;
   logic          i_ready = 1'b1;
   logic          o_taken;
   logic [N-1:0]  o_next_pc;
   logic [3:0]    o_flags;
   logic [15:0]   o_taken_cnt;

   logic          w4_ready, w4_valid, w4_taken;
   logic [N-1:0]  w4_next_pc;
   logic [3:0]    w4_flags;
   logic [3:0]    w4_taken_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 i_clk = ~i_clk;

   nzcv_cond_unit #(.N(N), .CNT_W(16), .RESET_NZCV(4'b0000)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_nzcv(i_nzcv), .i_set_flags(i_set_flags),
      .i_valid(i_valid), .o_ready(o_ready), .i_cond(i_cond), .i_pc(i_pc),
      .i_target(i_target), .o_valid(o_valid), .i_ready(i_ready), .o_taken(o_taken),
      .o_next_pc(o_next_pc), .o_flags(o_flags), .o_taken_cnt(o_taken_cnt)
   );

   // Narrow-counter instance sharing the same stimulus, used for saturation.
   nzcv_cond_unit #(.N(N), .CNT_W(4), .RESET_NZCV(4'b0000)) dut4 (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_nzcv(i_nzcv), .i_set_flags(i_set_flags),
      .i_valid(i_valid), .o_ready(w4_ready), .i_cond(i_cond), .i_pc(i_pc),
      .i_target(i_target), .o_valid(w4_valid), .i_ready(i_ready), .o_taken(w4_taken),
      .o_next_pc(w4_next_pc), .o_flags(w4_flags), .o_taken_cnt(w4_taken_cnt)
   );

   // ---------------- behavioural model ----------------
   logic          m_valid;
   logic          m_taken;
   logic [N-1:0]  m_next_pc;
   logic [3:0]    m_flags;
   int            m_cnt;
   int            m_cnt4;
   logic [N:0]    dut_q[$];   // {taken, next_pc} delivered by the DUT

   // Condition truth table written out by mnemonic.
   function automatic logic cond_model(input logic [3:0] cond, input logic [3:0] f);
      logic n, z, c, v;
      n = f[3]; z = f[2]; c = f[1]; v = f[0];
      case (cond)
         4'd0:  return z;                  // EQ
         4'd1:  return !z;                 // NE
         4'd2:  return c;                  // CS
         4'd3:  return !c;                 // CC
         4'd4:  return n;                  // MI
         4'd5:  return !n;                 // PL
         4'd6:  return v;                  // VS
         4'd7:  return !v;                 // VC
         4'd8:  return c && !z;            // HI
         4'd9:  return !c || z;            // LS
         4'd10: return n == v;             // GE
         4'd11: return n != v;             // LT
         4'd12: return !z && (n == v);     // GT
         4'd13: return z || (n != v);      // LE
         default: return 1'b1;             // AL, NV
      endcase
   endfunction

   task automatic model_reset();
      m_valid = 1'b0; m_taken = 1'b0; m_next_pc = '0; m_flags = 4'b0000;
      m_cnt = 0; m_cnt4 = 0;
   endtask

   task automatic set_in(input logic v, input logic [3:0] cond, input logic [N-1:0] pc,
                         input logic [N-1:0] tgt, input logic sf, input logic [3:0] nzcv,
                         input logic rdy);
      i_valid = v; i_cond = cond; i_pc = pc; i_target = tgt;
      i_set_flags = sf; i_nzcv = nzcv; i_ready = rdy;
   endtask

   // One clock: log DUT handshakes at negedge, advance model at posedge, settle.
   task automatic tick();
      logic [3:0] eff;
      logic       acc, t;
      @(negedge i_clk);
      if (o_valid && i_ready) dut_q.push_back({o_taken, o_next_pc});
      @(posedge i_clk);
      eff = i_set_flags ? i_nzcv : m_flags;
      acc = i_valid && (!m_valid || i_ready);
      if (acc) begin
         t = cond_model(i_cond, eff);
         m_valid = 1'b1;
         m_taken = t;
         m_next_pc = t ? i_target : i_pc + 64'd4;
         if (t && m_cnt < 65535) m_cnt++;
         if (t && m_cnt4 < 15) m_cnt4++;
      end else if (m_valid && i_ready) begin
         m_valid = 1'b0;
      end
      if (i_set_flags) m_flags = i_nzcv;
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      set_in(0, 4'h0, '0, '0, 0, 4'h0, 1);
      i_rst_n = 1'b0;
      #3;
      model_reset();
      n_cmp++;
      if ({o_valid, o_taken, o_next_pc, o_flags, o_taken_cnt, o_ready} !==
          {1'b0, 1'b0, 64'd0, 4'b0000, 16'd0, 1'b1}) begin
         n_bad++;
         $display("FAIL reset_state: got v=%b t=%b pc=%h f=%b cnt=%0d rdy=%b, want 0 0 0 0000 0 1",
                  o_valid, o_taken, o_next_pc, o_flags, o_taken_cnt, o_ready);
      end
      @(negedge i_clk);
      i_rst_n = 1'b1;
      tick();
      n_cmp++;
      if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_release: got v=%b rdy=%b, want 0 1", o_valid, o_ready);
      end
      $display("test_reset: done");
   endtask

   task automatic test_directed();
      // EQ with flags 0000 -> not taken, pc+4
      set_in(1, 4'b0000, 64'h100, 64'h200, 0, 4'h0, 1);
      tick();
      n_cmp++;
      if ({o_valid, o_taken, o_next_pc, o_taken_cnt} !== {1'b1, 1'b0, 64'h104, 16'd0}) begin
         n_bad++;
         $display("FAIL eq_not_taken: got v=%b t=%b pc=%h cnt=%0d, want 1 0 104 0",
                  o_valid, o_taken, o_next_pc, o_taken_cnt);
      end
      $display("directed EQ flags=0000: taken=%b next_pc=%h", o_taken, o_next_pc);
      // Same-cycle flag write is forwarded into the query
      set_in(1, 4'b0000, 64'h100, 64'h200, 1, 4'b0100, 1);
      tick();
      n_cmp++;
      if ({o_valid, o_taken, o_next_pc, o_flags, o_taken_cnt} !==
          {1'b1, 1'b1, 64'h200, 4'b0100, 16'd1}) begin
         n_bad++;
         $display("FAIL eq_forward: got v=%b t=%b pc=%h f=%b cnt=%0d, want 1 1 200 0100 1",
                  o_valid, o_taken, o_next_pc, o_flags, o_taken_cnt);
      end
      $display("directed EQ forwarded 0100: taken=%b next_pc=%h", o_taken, o_next_pc);
      set_in(0, 4'h0, '0, '0, 0, 4'h0, 1);
      tick();
   endtask

   task automatic test_sweep();
      int bad_before;
      bad_before = n_bad;
      for (int f = 0; f < 16; f++) begin
         for (int c = 0; c < 16; c++) begin
            set_in(0, 4'h0, '0, '0, 1, 4'(f), 1);
            tick();
            set_in(1, 4'(c), 64'h4000 + 64'(c), 64'h8000 + 64'(f), 0, 4'h0, 1);
            tick();
            n_cmp++;
            if ({o_valid, o_taken, o_next_pc} !== {m_valid, m_taken, m_next_pc}) begin
               n_bad++;
               $display("FAIL sweep cond=%h flags=%b: got t=%b pc=%h, want t=%b pc=%h",
                        c, f, o_taken, o_next_pc, m_taken, m_next_pc);
            end
            // Named corner cases, with hand-derived expectations
            if ((c == 11 && f == 4'b1000) || (c == 15)) begin
               n_cmp++;
               if (o_taken !== 1'b1) begin
                  n_bad++;
                  $display("FAIL sweep_corner cond=%h flags=%b: got t=%b, want 1", c, f, o_taken);
               end
            end
            if (c == 13 && (f == 4'b0000 || f == 4'b1001)) begin
               n_cmp++;
               if (o_taken !== 1'b0) begin
                  n_bad++;
                  $display("FAIL sweep_le cond=%h flags=%b: got t=%b, want 0", c, f, o_taken);
               end
            end
         end
      end
      set_in(0, 4'h0, '0, '0, 0, 4'h0, 1);
      tick();
      $display("test_sweep: 256 combinations, %0d new errors", n_bad - bad_before);
   endtask

   task automatic test_stall();
      logic [N:0] exp_b;
      dut_q.delete();
      set_in(1, 4'hE, 64'h1000, 64'hA000, 0, 4'h0, 1);   // A: AL
      tick();
      set_in(1, 4'h0, 64'h2000, 64'hB000, 0, 4'h0, 0);   // B held, downstream stalled
      #1;
      n_cmp++;
      if (o_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL stall_ready: got %b, want 0", o_ready);
      end
      for (int k = 0; k < 3; k++) begin
         tick();
         n_cmp++;
         if ({o_valid, o_taken, o_next_pc, o_ready} !== {1'b1, 1'b1, 64'hA000, 1'b0}) begin
            n_bad++;
            $display("FAIL stall_hold cyc=%0d: got v=%b t=%b pc=%h rdy=%b, want 1 1 a000 0",
                     k, o_valid, o_taken, o_next_pc, o_ready);
         end
      end
      i_ready = 1'b1;   // A drains, B accepted in the same edge
      tick();
      exp_b = {m_taken, m_next_pc};
      n_cmp++;
      if ({o_valid, o_taken, o_next_pc} !== {1'b1, exp_b}) begin
         n_bad++;
         $display("FAIL stall_b: got v=%b t=%b pc=%h, want 1 %b %h",
                  o_valid, o_taken, o_next_pc, exp_b[N], exp_b[N-1:0]);
      end
      set_in(0, 4'h0, '0, '0, 0, 4'h0, 1);
      tick();
      n_cmp++;
      if (dut_q.size() != 2 || dut_q[0] !== {1'b1, 64'hA000} || dut_q[1] !== exp_b) begin
         n_bad++;
         $display("FAIL stall_order: got %0d results, want 2 in order A,B", dut_q.size());
      end
      $display("test_stall: %0d results delivered", dut_q.size());
   endtask

   task automatic test_wrap();
      set_in(1, 4'h0, 64'hFFFF_FFFF_FFFF_FFFE, 64'h300, 1, 4'b0000, 1);  // EQ, Z=0
      tick();
      n_cmp++;
      if ({o_taken, o_next_pc} !== {1'b0, 64'd2}) begin
         n_bad++;
         $display("FAIL pc_wrap: got t=%b pc=%h, want 0 2", o_taken, o_next_pc);
      end
      $display("test_wrap: next_pc=%h", o_next_pc);
   endtask

   task automatic test_saturate();
      for (int k = 0; k < 20; k++) begin
         set_in(1, 4'hE, 64'(k), 64'h7000, 0, 4'h0, 1);
         tick();
      end
      set_in(0, 4'h0, '0, '0, 0, 4'h0, 1);
      tick();
      n_cmp++;
      if (w4_taken_cnt !== 4'hF) begin
         n_bad++;
         $display("FAIL cnt_sat4: got %0d, want 15", w4_taken_cnt);
      end
      n_cmp++;
      if (o_taken_cnt !== 16'(m_cnt)) begin
         n_bad++;
         $display("FAIL cnt16: got %0d, want %0d", o_taken_cnt, m_cnt);
      end
      $display("test_saturate: cnt4=%0d cnt16=%0d", w4_taken_cnt, o_taken_cnt);
   endtask

   task automatic test_random();
      int bad_before;
      bad_before = n_bad;
      for (int k = 0; k < 400; k++) begin
         set_in(1'($urandom_range(0, 3) != 0), 4'($urandom), {$urandom, $urandom},
                {$urandom, $urandom}, 1'($urandom_range(0, 2) == 0), 4'($urandom),
                1'($urandom_range(0, 3) != 0));
         #1;
         n_cmp++;
         if (o_ready !== (!m_valid || i_ready)) begin
            n_bad++;
            $display("FAIL rand_ready k=%0d: got %b, want %b", k, o_ready, !m_valid || i_ready);
         end
         tick();
         n_cmp++;
         if ({o_valid, o_taken, o_next_pc, o_flags, o_taken_cnt} !==
             {m_valid, m_taken, m_next_pc, m_flags, 16'(m_cnt)}) begin
            n_bad++;
            $display("FAIL rand k=%0d: got v=%b t=%b pc=%h f=%b cnt=%0d, want v=%b t=%b pc=%h f=%b cnt=%0d",
                     k, o_valid, o_taken, o_next_pc, o_flags, o_taken_cnt,
                     m_valid, m_taken, m_next_pc, m_flags, m_cnt);
         end
      end
      set_in(0, 4'h0, '0, '0, 0, 4'h0, 1);
      tick();
      $display("test_random: 400 cycles, %0d new errors", n_bad - bad_before);
   endtask

   task automatic test_reset_stall();
      set_in(1, 4'hE, 64'h50, 64'h900, 1, 4'b1011, 1);
      tick();
      set_in(0, 4'h0, '0, '0, 0, 4'h0, 0);
      tick();
      n_cmp++;
      if (o_valid !== 1'b1 || o_flags !== 4'b1011) begin
         n_bad++;
         $display("FAIL pre_reset_stall: got v=%b f=%b, want 1 1011", o_valid, o_flags);
      end
      #2;
      i_rst_n = 1'b0;
      #1;
      model_reset();
      n_cmp++;
      if ({o_valid, o_flags, o_taken_cnt, w4_taken_cnt} !== {1'b0, 4'b0000, 16'd0, 4'd0}) begin
         n_bad++;
         $display("FAIL async_reset: got v=%b f=%b cnt=%0d cnt4=%0d, want 0 0000 0 0",
                  o_valid, o_flags, o_taken_cnt, w4_taken_cnt);
      end
      @(negedge i_clk);
      i_rst_n = 1'b1;
      i_ready = 1'b1;
      tick();
      n_cmp++;
      if ({o_valid, o_taken_cnt} !== {1'b0, 16'd0}) begin
         n_bad++;
         $display("FAIL post_reset: got v=%b cnt=%0d, want 0 0", o_valid, o_taken_cnt);
      end
      $display("test_reset_stall: done");
   endtask

   initial begin
      model_reset();
      test_reset();
      test_directed();
      test_sweep();
      test_stall();
      test_wrap();
      test_saturate();
      test_random();
      test_reset_stall();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Global time limit so the run always ends.
   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, compared=%0d", n_cmp);
      $fatal(1, "timeout");
   end
endmodule
